// File: rtl/line_fill_pkg.sv
// Shared types and width helpers for the line-fill sequencer slice.
package line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fill_state_e;

  // log2 of backend beats per line, given frontend word-offset bits and word widths.
  function automatic int calc_line2mem_w(input int word_off_w, input int fe_data_w,
                                         input int be_data_w);
    return word_off_w - $clog2(be_data_w / fe_data_w);
  endfunction

endpackage

// File: rtl/line_fill_sequencer_if.sv
// Miss, read-channel and data-memory signals of the line-fill sequencer.
interface line_fill_sequencer_if
  import line_fill_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BE_DATA_W = 32,
  parameter int BYTE_W    = $clog2(BE_DATA_W / 8),
  parameter int L2M_W     = calc_line2mem_w(3, 32, BE_DATA_W)
);
  logic                   miss_valid;
  logic [ADDR_W-1:0]      miss_addr;
  logic                   fill_busy;
  logic                   fill_done;
  logic                   replace_valid;
  logic [ADDR_W-1:BYTE_W] replace_addr;
  logic                   replace;
  logic                   read_valid;
  logic [BE_DATA_W-1:0]   read_rdata;
  logic                   dmem_we;
  logic [L2M_W-1:0]       dmem_addr;
  logic [BE_DATA_W-1:0]   dmem_wdata;

  // Sequencer view.
  modport slave (
    input  miss_valid, miss_addr, replace, read_valid, read_rdata,
    output fill_busy, fill_done, replace_valid, replace_addr, dmem_we, dmem_addr, dmem_wdata
  );

  // Cache controller / read channel / memory view.
  modport master (
    output miss_valid, miss_addr, replace, read_valid, read_rdata,
    input  fill_busy, fill_done, replace_valid, replace_addr, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/line_fill_beat_ctr.sv
// Beat index (wrapping position in the line) and beat count (beats completed) for one fill.
module line_fill_beat_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_idx,
  output logic [W-1:0] beat_idx,
  output logic         last
);
  logic [W-1:0] beat_idx_q, beat_idx_d;
  logic [W-1:0] beat_cnt_q, beat_cnt_d;

  // The index wraps modulo 2**W by plain overflow, which gives the critical-word-first order.
  always_comb begin
    beat_idx_d = beat_idx_q;
    beat_cnt_d = beat_cnt_q;
    if (load) begin
      beat_idx_d = load_idx;
      beat_cnt_d = '0;
    end else if (inc) begin
      beat_idx_d = beat_idx_q + W'(1);
      beat_cnt_d = beat_cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      beat_idx_q <= beat_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_idx = beat_idx_q;
  assign last     = (beat_cnt_q == '1);
endmodule

// File: rtl/line_fill_sequencer.sv
// Cache line-fill sequencer: one single-beat read per backend word, written to dmem by beat index.
// Optional build macro LINE_FILL_CRITICAL_WORD_FIRST_EN starts the fill at the missing beat.
module line_fill_sequencer
  import line_fill_pkg::*;
#(
  parameter int CACHE_FRONTEND_ADDR_W = 32,
  parameter int CACHE_FRONTEND_DATA_W = 32,
  parameter int CACHE_WORD_OFF_W      = 3,
  parameter int CACHE_BACKEND_DATA_W  = 32,
  parameter int CACHE_BACKEND_BYTE_W  = $clog2(CACHE_BACKEND_DATA_W / 8),
  parameter int CACHE_LINE2MEM_W      = calc_line2mem_w(CACHE_WORD_OFF_W,
                                          CACHE_FRONTEND_DATA_W, CACHE_BACKEND_DATA_W)
) (
  input logic            ap_clk,
  input logic            ap_rst_n,
  line_fill_sequencer_if.slave bus
);
  localparam int ADDR_W = CACHE_FRONTEND_ADDR_W;
  localparam int BYTE_W = CACHE_BACKEND_BYTE_W;
  localparam int L2M_W  = CACHE_LINE2MEM_W;
  localparam int TAG_W  = ADDR_W - L2M_W - BYTE_W;

  fill_state_e      state_q, state_d;
  logic [TAG_W-1:0] line_tag_q, line_tag_d;
  logic             ctr_load, ctr_inc, ctr_last;
  logic [L2M_W-1:0] start_beat, beat_idx;

`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  assign start_beat = bus.miss_addr[L2M_W+BYTE_W-1:BYTE_W];
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.miss_addr[BYTE_W-1:0];
`else
  assign start_beat = '0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.miss_addr[L2M_W+BYTE_W-1:0];
`endif

  line_fill_beat_ctr #(.W(L2M_W)) u_beat_ctr (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .load     (ctr_load),
    .inc      (ctr_inc),
    .load_idx (start_beat),
    .beat_idx (beat_idx),
    .last     (ctr_last)
  );

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      line_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      line_tag_q <= line_tag_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    line_tag_d = line_tag_q;
    ctr_load   = 1'b0;
    ctr_inc    = 1'b0;
    case (state_q)
      IDLE: if (bus.miss_valid) begin
        line_tag_d = bus.miss_addr[ADDR_W-1 -: TAG_W];
        ctr_load   = 1'b1;
        state_d    = REQ;
      end
      REQ:  if (bus.replace) state_d = WAIT;
      // replace falling marks a completed transaction; retried beats never advance the index.
      WAIT: if (!bus.replace) begin
        if (ctr_last) begin
          state_d = DONE;
        end else begin
          ctr_inc = 1'b1;
          state_d = REQ;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.fill_busy     = (state_q == REQ) || (state_q == WAIT);
    bus.fill_done     = (state_q == DONE);
    bus.replace_valid = (state_q == REQ);
    bus.replace_addr  = '0;
    bus.dmem_we       = 1'b0;
    bus.dmem_addr     = '0;
    bus.dmem_wdata    = '0;
    if (state_q == REQ) bus.replace_addr = {line_tag_q, beat_idx};
    if ((state_q == WAIT) && bus.read_valid && bus.replace) begin
      bus.dmem_we    = 1'b1;
      bus.dmem_addr  = beat_idx;
      bus.dmem_wdata = bus.read_rdata;
    end
  end
endmodule

// File: tb/tb_line_fill_sequencer.sv
// Directed bench for line_fill_sequencer with a simple single-beat read-channel model.
module tb_line_fill_sequencer;
`ifdef LINE_FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   n_req = 0;

  always #5 ap_clk = ~ap_clk;

  line_fill_sequencer_if #(.ADDR_W(32), .BE_DATA_W(32), .BYTE_W(2), .L2M_W(3)) bus ();

  line_fill_sequencer dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave)
  );

  always @(negedge ap_clk) if (bus.fill_done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, bus.fill_busy, 0);
    check({tag, "_done"}, bus.fill_done, 0);
    check({tag, "_rv"}, bus.replace_valid, 0);
    check({tag, "_raddr"}, bus.replace_addr, 0);
    check({tag, "_we"}, bus.dmem_we, 0);
    check({tag, "_daddr"}, bus.dmem_addr, 0);
    check({tag, "_wdata"}, bus.dmem_wdata, 0);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.replace_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge ap_clk);
    end
  endtask

  // Accept one request, return one beat (optionally preceded by an error beat), drop replace.
  task automatic serve_beat(input logic [29:0] exp_addr, input bit retry, input bit poke,
                            input bit rst_mid);
    bit          ok;
    logic [2:0]  idx;
    logic [31:0] data;
    wait_req(ok);
    check("req_seen", ok, 1);
    if (!ok) return;
    check("replace_addr", bus.replace_addr, exp_addr);
    n_req++;
    idx  = exp_addr[2:0];
    data = 32'hA0 + 32'(idx);
    @(negedge ap_clk);
    bus.replace = 1'b1;
    @(negedge ap_clk);
    check("rv_low_in_wait", bus.replace_valid, 0);
    if (retry) begin
      bus.read_valid = 1'b1;
      bus.read_rdata = 32'hDEAD;
      #1;
      check("retry_we", bus.dmem_we, 1);
      check("retry_addr", bus.dmem_addr, idx);
      check("retry_wdata", bus.dmem_wdata, 32'hDEAD);
      @(negedge ap_clk);
      bus.read_valid = 1'b0;
      @(negedge ap_clk);
    end
    if (poke) begin
      bus.miss_valid = 1'b1;
      bus.miss_addr  = 32'h0000_0040;
      @(negedge ap_clk);
      bus.miss_valid = 1'b0;
    end
    bus.read_valid = 1'b1;
    bus.read_rdata = data;
    #1;
    check("beat_we", bus.dmem_we, 1);
    check("beat_addr", bus.dmem_addr, idx);
    check("beat_wdata", bus.dmem_wdata, data);
    if (rst_mid) begin
      ap_rst_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      bus.read_valid = 1'b0;
      bus.replace    = 1'b0;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      return;
    end
    @(negedge ap_clk);
    bus.read_valid = 1'b0;
    bus.read_rdata = $urandom;
    #1;
    check("no_we_after_beat", bus.dmem_we, 0);
    bus.replace = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] addr, input bit retry, input int poke_pos,
                         input int rst_pos);
    logic [2:0] start;
    logic [2:0] b;
    int         d0;
    d0    = done_seen;
    n_req = 0;
    start = CWF ? addr[4:2] : 3'd0;
    @(negedge ap_clk);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    @(negedge ap_clk);
    bus.miss_valid = 1'b0;
    check("busy_t1", bus.fill_busy, 1);
    check("rv_t1", bus.replace_valid, 1);
    for (int k = 0; k < 8; k++) begin
      b = 3'(start + 3'(k));
      serve_beat({addr[31:5], b}, retry && (b == 3'd3), k == poke_pos, k == rst_pos);
      if (k == rst_pos) begin
        repeat (4) @(negedge ap_clk);
        check("midrst_no_done", done_seen - d0, 0);
        check("midrst_idle", bus.fill_busy, 0);
        return;
      end
      @(negedge ap_clk);
      if (k < 7) begin
        check("req_next_cycle", bus.replace_valid, 1);
        if (k == 0) begin
          bus.read_valid = 1'b1;
          #1;
          check("stray_read_ignored", bus.dmem_we, 0);
          bus.read_valid = 1'b0;
        end
      end else begin
        check("fill_done_pulse", bus.fill_done, 1);
        check("busy_in_done", bus.fill_busy, 0);
      end
    end
    @(negedge ap_clk);
    check("fill_done_low", bus.fill_done, 0);
    repeat (3) @(negedge ap_clk);
    check("no_extra_req", bus.replace_valid, 0);
    check("done_count", done_seen - d0, 1);
    check("req_count", n_req, 8);
  endtask

  initial begin
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    bus.replace    = 1'b0;
    bus.read_valid = 1'b0;
    bus.read_rdata = '0;

    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      bus.miss_valid = 1'($urandom);
      bus.miss_addr  = $urandom;
      bus.replace    = 1'($urandom);
      bus.read_valid = 1'($urandom);
      bus.read_rdata = $urandom;
      #1;
      check_outputs_zero("reset");
    end
    bus.miss_valid = 1'b0;
    bus.replace    = 1'b0;
    bus.read_valid = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_outputs_zero("post_reset");

    do_fill(32'h0000_1234, 1'b0, -1, -1);
    do_fill(32'h0000_1234, 1'b1, -1, -1);
    do_fill(32'h8000_0FE8, 1'b0, 2, -1);
    do_fill(32'h0000_1234, 1'b0, -1, 4);
    do_fill(32'h0000_1234, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end
endmodule
